rv32i_core: RTL and testbench
=============================

Name: rv32i_core

Overview:
- Single-cycle RV32I integer processor: one instruction fetched, decoded, executed and retired per rising clock edge.
- Contains internal word-addressed instruction memory, data memory, a 32x32 register file, an ALU and operand/PC muxes.
- Top-level simulation target; benches preload memories and registers hierarchically, then observe internal state.

Parameters:
- XLEN, 32, datapath width.
- MEM_WORDS, 1024, depth in 32-bit words of each of insn_memory.mem and data_memory.mem.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.

Behaviour:
- Observability (mandatory hierarchical names):
  - pc: current PC.
  - pc_in: next PC.
  - instruction_mux_out: current instruction.
  - mux_a_out, mux_b_out: ALU operands.
  - alu_out: ALU result.
  - register_file.regFile[0:31]: register array.
  - insn_memory.mem[0:MEM_WORDS-1], data_memory.mem[0:MEM_WORDS-1]: memory arrays.
  - All arrays are plain reg arrays, writable from a bench at time 0.
- Reset:
  - On a rising clk edge with reset==0, pc <= RESET_PC; no register or memory write occurs that cycle.
  - Register file and memories are not cleared by reset; preloaded contents survive.
- Fetch: instruction_mux_out = insn_memory.mem[pc[11:2]] (combinational, word index, upper PC bits ignored).
- Register file:
  - Two combinational read ports.
  - One write port, written at the rising edge.
  - Reads of x0 return 0; writes to x0 are discarded.
- Operand muxes:
  - mux_a_out: rs1, or pc for AUIPC/JAL/branch target.
  - mux_b_out: rs2, or sign-extended immediate (I/S/B/U/J formats).
- Supported instructions:
  - LUI, AUIPC, JAL, JALR.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LW, SW. LB/LBU/LH/LHU/SB/SH optional; if implemented, use little-endian lanes.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- Arithmetic: 32-bit wrap-around; shifts use the low 5 bits of the shift amount; SLT/SLTI signed, SLTU/SLTIU unsigned.
- Next PC (pc_in):
  - Default pc+4.
  - Taken branch / JAL: pc+imm.
  - JALR: (rs1+imm) & ~1.
  - JAL/JALR write pc+4 to rd.
- Data memory:
  - Loads are combinational reads of data_memory.mem[addr[11:2]].
  - Stores write at the rising edge.
- Unknown or all-zero instruction: executes as NOP; no register or memory write, pc <= pc+4.
- Simultaneous events:
  - The register write and PC update of one instruction occur at the same edge.
  - The next instruction reads the updated register; no hazards exist, since the design is single-cycle.

Test Plan:
- Reset pulse low, then high, before the first clk edge; regFile[k]=k preloaded; insn mem[0]=0x01608093 (ADDI x1,x1,22), mem[1]=0x0120F113 (ANDI x2,x1,18) -> after 1st edge x1=23, pc=4; after 2nd edge x2=18, x3 stays 3; subsequent zero words act as NOPs, registers unchanged.
- Hold reset=0 across two edges with pc nonzero -> pc=0; regFile unchanged.
- ADD x3,x1,x2 with x1=0xFFFFFFFF, x2=1 -> x3=0. SUB x3,x1,x2 with x1=5, x2=7 -> x3=0xFFFFFFFE. SRAI by 4 on 0x80000000 -> 0xF8000000.
- SW x2,8(x0) with x2=0xDEADBEEF, then LW x5,8(x0) -> data_memory.mem[2]=0xDEADBEEF; x5=0xDEADBEEF.
- BEQ x1,x1,+8 at pc=0 -> pc=8. BNE x1,x1,+8 -> pc=4. JAL x1,+16 at pc=4 -> x1=8, pc=20. JALR x0,0(x1) -> pc=8.
- ADDI x0,x0,5 -> regFile[0] reads 0; LUI x4,0x12345 -> x4=0x12345000; AUIPC x4,1 at pc=12 -> x4=0x0000100C.

Source files
------------

// File: rtl/rv32i_core.sv
// Single-cycle RV32I core: fetch, decode, execute and retire one instruction per clock.
// Instruction and data memories are word arrays indexed by address bits [AW+1:2].

module register_file #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);
  logic [XLEN-1:0] regFile [0:31];

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regFile[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regFile[raddr2];

  always_ff @(posedge clk) begin
    if (we && (waddr != 5'd0)) regFile[waddr] <= wdata;
  end
endmodule

module word_memory #(
  parameter int XLEN  = 32,
  parameter int WORDS = 1024
) (
  input  logic                     clk,
  input  logic [$clog2(WORDS)-1:0] index,
  input  logic [XLEN/8-1:0]        be,
  input  logic [XLEN-1:0]          wdata,
  output logic [XLEN-1:0]          rdata
);
  logic [XLEN-1:0] mem [0:WORDS-1];

  assign rdata = mem[index];

  always_ff @(posedge clk) begin
    for (int i = 0; i < XLEN/8; i++) begin
      if (be[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
    end
  end
endmodule

module rv32i_core #(
  parameter int              XLEN      = 32,
  parameter int              MEM_WORDS = 1024,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input logic clk,
  input logic reset
);
  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  typedef enum logic [1:0] {WB_ALU, WB_LOAD, WB_LINK} wb_sel_t;

  logic [XLEN-1:0] pc, pc_in, pc_plus4;
  logic [XLEN-1:0] instruction_mux_out;
  logic [XLEN-1:0] mux_a_out, mux_b_out, alu_out;
  logic [XLEN-1:0] rs1_data, rs2_data, imm, wb_data;
  logic [XLEN-1:0] dmem_rdata, load_shift, load_data, store_data;
  logic [3:0]      store_be;
  logic [1:0]      byte_off;

  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;

  alu_op_t alu_op;
  wb_sel_t wb_sel;
  logic    a_sel_pc, b_sel_imm, reg_we, is_store, is_branch, is_jal, is_jalr;
  logic    branch_taken;

  assign opcode   = instruction_mux_out[6:0];
  assign rd       = instruction_mux_out[11:7];
  assign funct3   = instruction_mux_out[14:12];
  assign rs1      = instruction_mux_out[19:15];
  assign rs2      = instruction_mux_out[24:20];
  assign funct7   = instruction_mux_out[31:25];
  assign pc_plus4 = pc + XLEN'(4);

  word_memory #(.XLEN(XLEN), .WORDS(MEM_WORDS)) insn_memory (
    .clk   (clk),
    .index (pc[AW+1:2]),
    .be    ('0),
    .wdata ('0),
    .rdata (instruction_mux_out)
  );

  register_file #(.XLEN(XLEN)) register_file (
    .clk    (clk),
    .we     (reg_we && reset),
    .waddr  (rd),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  // Decode: anything not recognised leaves every write enable low, so it retires as a NOP.
  always_comb begin
    imm       = '0;
    a_sel_pc  = 1'b0;
    b_sel_imm = 1'b0;
    alu_op    = ALU_ADD;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    case (opcode)
      OP_LUI: begin
        imm       = {instruction_mux_out[31:12], 12'b0};
        b_sel_imm = 1'b1;
        alu_op    = ALU_PASS_B;
        reg_we    = 1'b1;
      end
      OP_AUIPC: begin
        imm       = {instruction_mux_out[31:12], 12'b0};
        a_sel_pc  = 1'b1;
        b_sel_imm = 1'b1;
        reg_we    = 1'b1;
      end
      OP_JAL: begin
        imm       = {{11{instruction_mux_out[31]}}, instruction_mux_out[31],
                     instruction_mux_out[19:12], instruction_mux_out[20],
                     instruction_mux_out[30:21], 1'b0};
        a_sel_pc  = 1'b1;
        b_sel_imm = 1'b1;
        reg_we    = 1'b1;
        wb_sel    = WB_LINK;
        is_jal    = 1'b1;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          imm       = {{20{instruction_mux_out[31]}}, instruction_mux_out[31:20]};
          b_sel_imm = 1'b1;
          reg_we    = 1'b1;
          wb_sel    = WB_LINK;
          is_jalr   = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (funct3[2:1] != 2'b01) begin
          imm       = {{19{instruction_mux_out[31]}}, instruction_mux_out[31],
                       instruction_mux_out[7], instruction_mux_out[30:25],
                       instruction_mux_out[11:8], 1'b0};
          a_sel_pc  = 1'b1;
          b_sel_imm = 1'b1;
          is_branch = 1'b1;
        end
      end
      OP_LOAD: begin
        if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) begin
          imm       = {{20{instruction_mux_out[31]}}, instruction_mux_out[31:20]};
          b_sel_imm = 1'b1;
          reg_we    = 1'b1;
          wb_sel    = WB_LOAD;
        end
      end
      OP_STORE: begin
        if (funct3[2] == 1'b0 && funct3[1:0] != 2'b11) begin
          imm       = {{20{instruction_mux_out[31]}}, instruction_mux_out[31:25],
                       instruction_mux_out[11:7]};
          b_sel_imm = 1'b1;
          is_store  = 1'b1;
        end
      end
      OP_IMM: begin
        imm       = {{20{instruction_mux_out[31]}}, instruction_mux_out[31:20]};
        b_sel_imm = 1'b1;
        case (funct3)
          3'b000: begin alu_op = ALU_ADD;  reg_we = 1'b1; end
          3'b010: begin alu_op = ALU_SLT;  reg_we = 1'b1; end
          3'b011: begin alu_op = ALU_SLTU; reg_we = 1'b1; end
          3'b100: begin alu_op = ALU_XOR;  reg_we = 1'b1; end
          3'b110: begin alu_op = ALU_OR;   reg_we = 1'b1; end
          3'b111: begin alu_op = ALU_AND;  reg_we = 1'b1; end
          3'b001: begin alu_op = ALU_SLL;  reg_we = (funct7 == 7'b0000000); end
          default: begin
            alu_op = (funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
            reg_we = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          end
        endcase
      end
      OP_REG: begin
        reg_we = 1'b1;
        case ({funct7, funct3})
          10'b0000000_000: alu_op = ALU_ADD;
          10'b0100000_000: alu_op = ALU_SUB;
          10'b0000000_001: alu_op = ALU_SLL;
          10'b0000000_010: alu_op = ALU_SLT;
          10'b0000000_011: alu_op = ALU_SLTU;
          10'b0000000_100: alu_op = ALU_XOR;
          10'b0000000_101: alu_op = ALU_SRL;
          10'b0100000_101: alu_op = ALU_SRA;
          10'b0000000_110: alu_op = ALU_OR;
          10'b0000000_111: alu_op = ALU_AND;
          default:         reg_we = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  assign mux_a_out = a_sel_pc  ? pc  : rs1_data;
  assign mux_b_out = b_sel_imm ? imm : rs2_data;

  always_comb begin
    case (alu_op)
      ALU_ADD:    alu_out = mux_a_out + mux_b_out;
      ALU_SUB:    alu_out = mux_a_out - mux_b_out;
      ALU_SLL:    alu_out = mux_a_out << mux_b_out[4:0];
      ALU_SLT:    alu_out = {{(XLEN-1){1'b0}}, $signed(mux_a_out) < $signed(mux_b_out)};
      ALU_SLTU:   alu_out = {{(XLEN-1){1'b0}}, mux_a_out < mux_b_out};
      ALU_XOR:    alu_out = mux_a_out ^ mux_b_out;
      ALU_SRL:    alu_out = mux_a_out >> mux_b_out[4:0];
      ALU_SRA:    alu_out = $signed(mux_a_out) >>> mux_b_out[4:0];
      ALU_OR:     alu_out = mux_a_out | mux_b_out;
      ALU_AND:    alu_out = mux_a_out & mux_b_out;
      ALU_PASS_B: alu_out = mux_b_out;
      default:    alu_out = '0;
    endcase
  end

  // Branch condition compares the registers; the ALU is busy forming the target.
  always_comb begin
    case (funct3)
      3'b000:  branch_taken = (rs1_data == rs2_data);
      3'b001:  branch_taken = (rs1_data != rs2_data);
      3'b100:  branch_taken = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  branch_taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  branch_taken = (rs1_data <  rs2_data);
      3'b111:  branch_taken = (rs1_data >= rs2_data);
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    if (is_jalr)                               pc_in = {alu_out[XLEN-1:1], 1'b0};
    else if (is_jal || (is_branch && branch_taken)) pc_in = alu_out;
    else                                       pc_in = pc_plus4;
  end

  assign byte_off = alu_out[1:0];

  // Sub-word stores replicate the data across lanes and enable only the addressed bytes.
  always_comb begin
    store_be   = 4'b0000;
    store_data = rs2_data;
    if (is_store && reset) begin
      case (funct3[1:0])
        2'b00: begin
          store_be   = 4'b0001 << byte_off;
          store_data = {4{rs2_data[7:0]}};
        end
        2'b01: begin
          store_be   = byte_off[1] ? 4'b1100 : 4'b0011;
          store_data = {2{rs2_data[15:0]}};
        end
        default: store_be = 4'b1111;
      endcase
    end
  end

  word_memory #(.XLEN(XLEN), .WORDS(MEM_WORDS)) data_memory (
    .clk   (clk),
    .index (alu_out[AW+1:2]),
    .be    (store_be),
    .wdata (store_data),
    .rdata (dmem_rdata)
  );

  assign load_shift = dmem_rdata >> {byte_off, 3'b000};

  always_comb begin
    case (funct3)
      3'b000:  load_data = {{24{load_shift[7]}}, load_shift[7:0]};
      3'b001:  load_data = {{16{load_shift[15]}}, load_shift[15:0]};
      3'b100:  load_data = {24'b0, load_shift[7:0]};
      3'b101:  load_data = {16'b0, load_shift[15:0]};
      default: load_data = dmem_rdata;
    endcase
  end

  always_comb begin
    case (wb_sel)
      WB_LOAD: wb_data = load_data;
      WB_LINK: wb_data = pc_plus4;
      default: wb_data = alu_out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) pc <= RESET_PC;
    else        pc <= pc_in;
  end
endmodule

// File: tb/tb_rv32i_core.sv
// Bench for rv32i_core: directed vector table, hand-written reset/memory sequences,
// and randomized ALU/branch instructions checked against an operation-level model.

module tb_rv32i_core;
  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  rv32i_core dut (
    .clk   (clk),
    .reset (reset)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    string       name;
    logic [31:0] insn;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] start_pc;
    int          rd;
    logic [31:0] exp_rd;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  // Operation order: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND
  logic [2:0] f3_tab [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_state;
    for (int k = 0; k < 32; k++) dut.register_file.regFile[k] = k;
    for (int i = 0; i < 64; i++) dut.insn_memory.mem[i] = 32'h0;
  endtask

  task automatic apply_reset;
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic add_vec(input string name, input logic [31:0] insn, input logic [31:0] x1,
                         input logic [31:0] x2, input logic [31:0] start_pc, input int rd,
                         input logic [31:0] exp_rd, input logic [31:0] exp_pc);
    vec_t v;
    v.name = name; v.insn = insn; v.x1 = x1; v.x2 = x2; v.start_pc = start_pc;
    v.rd = rd; v.exp_rd = exp_rd; v.exp_pc = exp_pc;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    clear_state();
    apply_reset();
    dut.register_file.regFile[1] = v.x1;
    dut.register_file.regFile[2] = v.x2;
    dut.insn_memory.mem[v.start_pc[11:2]] = v.insn;
    for (int s = 0; s < int'(v.start_pc[11:2]); s++) tick();
    tick();
    check({v.name, "_rd"}, dut.register_file.regFile[v.rd], v.exp_rd);
    check({v.name, "_pc"}, dut.pc, v.exp_pc);
  endtask

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a << sh;
      3: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4: return (a < b) ? 32'd1 : 32'd0;
      5: return a ^ b;
      6: return a >> sh;
      7: return 32'(int'(a) >>> sh);
      8: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic ref_branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return int'(a) < int'(b);
      3'd5: return int'(a) >= int'(b);
      3'd6: return a < b;
      default: return a >= b;
    endcase
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 4))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] a, b, bval, insn, exp_pc;
    logic [11:0] imm12;
    logic [12:0] boff;
    logic [2:0]  bf3;
    logic [2:0]  br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    int op;

    // Reset is held low across the first edge; the ADDI at address 0 must not retire then.
    clear_state();
    dut.insn_memory.mem[0] = 32'h0160_8093;
    dut.insn_memory.mem[1] = 32'h0120_F113;
    @(negedge clk);
    check("reset_pc", dut.pc, 32'h0);
    check("reset_no_write", dut.register_file.regFile[1], 32'd1);
    reset = 1'b1;
    tick();
    check("addi_x1", dut.register_file.regFile[1], 32'd23);
    check("addi_pc", dut.pc, 32'd4);
    tick();
    check("andi_x2", dut.register_file.regFile[2], 32'd18);
    check("andi_x3_kept", dut.register_file.regFile[3], 32'd3);
    tick();
    tick();
    check("nop_pc", dut.pc, 32'd16);
    check("nop_x1_kept", dut.register_file.regFile[1], 32'd23);
    check("nop_x2_kept", dut.register_file.regFile[2], 32'd18);

    // Reset held over two edges with pc nonzero; instruction at 0 must stay suppressed.
    reset = 1'b0;
    tick();
    check("hold_reset_pc1", dut.pc, 32'h0);
    tick();
    check("hold_reset_pc2", dut.pc, 32'h0);
    check("hold_reset_x1", dut.register_file.regFile[1], 32'd23);
    reset = 1'b1;

    add_vec("add_wrap",   32'h0020_81B3, 32'hFFFF_FFFF, 32'd1,         0,  3, 32'h0,         4);
    add_vec("sub_neg",    32'h4020_81B3, 32'd5,         32'd7,         0,  3, 32'hFFFF_FFFE, 4);
    add_vec("srai",       32'h4040_D193, 32'h8000_0000, 32'd0,         0,  3, 32'hF800_0000, 4);
    add_vec("slt",        32'h0020_A1B3, 32'd1,         32'hFFFF_FFFF, 0,  3, 32'd0,         4);
    add_vec("sltu",       32'h0020_B1B3, 32'd1,         32'hFFFF_FFFF, 0,  3, 32'd1,         4);
    add_vec("beq_taken",  32'h0010_8463, 32'd7,         32'd0,         0,  1, 32'd7,         8);
    add_vec("bne_not",    32'h0010_9463, 32'd7,         32'd0,         0,  1, 32'd7,         4);
    add_vec("blt_taken",  32'h0020_C463, 32'hFFFF_FFFF, 32'd1,         0,  1, 32'hFFFF_FFFF, 8);
    add_vec("bgeu_taken", 32'h0020_F463, 32'hFFFF_FFFF, 32'd1,         0,  1, 32'hFFFF_FFFF, 8);
    add_vec("jal",        32'h0100_00EF, 32'd0,         32'd2,         4,  1, 32'd8,         20);
    add_vec("jalr",       32'h0000_8067, 32'd8,         32'd2,         0,  1, 32'd8,         8);
    add_vec("jalr_lsb",   32'h0010_82E7, 32'd8,         32'd2,         0,  5, 32'd4,         8);
    add_vec("addi_x0",    32'h0050_0013, 32'd1,         32'd2,         0,  0, 32'd0,         4);
    add_vec("lui",        32'h1234_5237, 32'd1,         32'd2,         0,  4, 32'h1234_5000, 4);
    add_vec("auipc",      32'h0000_1217, 32'd1,         32'd2,         12, 4, 32'h0000_100C, 16);
    add_vec("unknown_op", 32'hFFFF_FFFF, 32'd1,         32'd2,         0, 31, 32'd31,        4);
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Store then load through the same word.
    clear_state();
    apply_reset();
    dut.data_memory.mem[2] = 32'h0;
    dut.register_file.regFile[2] = 32'hDEAD_BEEF;
    dut.insn_memory.mem[0] = 32'h0020_2423;
    dut.insn_memory.mem[1] = 32'h0080_2283;
    tick();
    check("sw_mem", dut.data_memory.mem[2], 32'hDEAD_BEEF);
    tick();
    check("lw_x5", dut.register_file.regFile[5], 32'hDEAD_BEEF);
    check("lw_pc", dut.pc, 32'd8);

    // Random register and immediate ALU operations.
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 9);
      a  = pick_val();
      b  = pick_val();
      if ($urandom_range(0, 1) == 1) begin
        if (op == 1) op = 0;
        if (op == 2 || op == 6 || op == 7) begin
          bval  = 32'($urandom_range(0, 31));
          imm12 = {(op == 7) ? 7'h20 : 7'h00, bval[4:0]};
        end else begin
          imm12 = 12'($urandom_range(0, 4095));
          bval  = 32'(signed'(imm12));
        end
        insn = {imm12, 5'd1, f3_tab[op], 5'd3, 7'b0010011};
      end else begin
        bval = b;
        insn = {(op == 1 || op == 7) ? 7'h20 : 7'h00, 5'd2, 5'd1, f3_tab[op], 5'd3, 7'b0110011};
      end
      exp_q.push_back(ref_alu(op, a, bval));
      clear_state();
      apply_reset();
      dut.register_file.regFile[1] = a;
      dut.register_file.regFile[2] = b;
      dut.insn_memory.mem[0] = insn;
      tick();
      check("rand_alu", dut.register_file.regFile[3], exp_q.pop_front());
      check("rand_alu_pc", dut.pc, 32'd4);
    end

    // Random conditional branches with forward offsets.
    for (int it = 0; it < 24; it++) begin
      bf3  = br_f3[$urandom_range(0, 5)];
      a    = pick_val();
      b    = ($urandom_range(0, 2) == 0) ? a : pick_val();
      boff = 13'(4 * $urandom_range(2, 15));
      insn = {boff[12], boff[10:5], 5'd2, 5'd1, bf3, boff[4:1], boff[11], 7'b1100011};
      exp_pc = ref_branch(bf3, a, b) ? 32'(boff) : 32'd4;
      clear_state();
      apply_reset();
      dut.register_file.regFile[1] = a;
      dut.register_file.regFile[2] = b;
      dut.insn_memory.mem[0] = insn;
      tick();
      check("rand_branch_pc", dut.pc, exp_pc);
      check("rand_branch_x3", dut.register_file.regFile[3], 32'd3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
